// File: rtl/encdec_pkg.sv
// Shared widths and key expansion for the encrypt/decrypt stage-4 pair.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package encdec_pkg;

  localparam int KEY_W   = 11;
  localparam int DATA_W  = 60;
  localparam int Y_W     = 61;
  localparam int TAG_W   = 6;
  localparam int FRAME_W = 78;

  // Expands an 11-bit key into the 60-bit additive mask.
  // Segments from the LSB are k, ~k, ~k, k, ~k and then k[4:0] on top.
  // Decryption stage 4 calls this same function, so both sides stay in lockstep.
  function automatic logic [DATA_W-1:0] key_expand(input logic [KEY_W-1:0] k);
    return {k[4:0], ~k, k, ~k, ~k, k};
  endfunction

  // An all-zero LFSR state would lock up, so zero seeds are mapped to 1.
  function automatic logic [KEY_W-1:0] fix_seed(input logic [KEY_W-1:0] s);
    return (s == '0) ? KEY_W'(1) : s;
  endfunction

endpackage

// File: rtl/key_lfsr11.sv
// 11-bit Fibonacci LFSR (x^11 + x^9 + 1, period 2047) that supplies per-word keys.
// Latency: q shows the new state one edge after adv or load.
// Backpressure: holds its state unless adv or load is asserted; load has priority over adv.
module key_lfsr11
  import encdec_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED = 11'h001
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             adv,
  input  logic             load,
  input  logic [KEY_W-1:0] seed,
  output logic [KEY_W-1:0] q
);

  // State update: reset to the seed, reload on request, otherwise shift when advanced.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      q <= fix_seed(SEED);
    end else if (load) begin
      q <= fix_seed(seed);
    end else if (adv) begin
      q <= {q[9:0], q[10] ^ q[8]};
    end
  end

endmodule

// File: rtl/encrypt_stage_4.sv
// Masks each 60-bit plaintext word with an LFSR-derived key and frames it as {key, y, tag}.
// Latency: 2 cycles from input accept to out_valid; sustains 1 word per cycle.
// Backpressure: full valid/ready; the output holds while stalled and in_ready drops once both stages are full.
module encrypt_stage_4
  import encdec_pkg::*;
#(
  parameter logic [KEY_W-1:0] SEED     = 11'h001,
  parameter logic [TAG_W-1:0] TAG_INIT = 6'h00
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               key_load,
  input  logic [KEY_W-1:0]   key_seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FRAME_W-1:0] out_data
);

  logic              adv2;
  logic              accept;
  logic [KEY_W-1:0]  lfsr_q;
  logic [TAG_W-1:0]  tag;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [KEY_W-1:0]  s1_key;
  logic [TAG_W-1:0]  s1_tag;

  logic [DATA_W-1:0] mask_b;
  logic [Y_W-1:0]    padded_x;
  logic [Y_W-1:0]    sum_y;

  // The output register can take a new frame when it is empty or is being drained this cycle.
  // Stage 1 can accept when it is empty or is handing its word on to stage 2 in the same edge.
  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign accept   = in_valid && in_ready;

  // The LFSR steps only on accepted words.
  // A same-cycle reload wins over the step, but the accepted word still latches the old key.
  key_lfsr11 #(
    .SEED (SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .adv   (accept),
    .load  (key_load),
    .seed  (key_seed),
    .q     (lfsr_q)
  );

  // Sequence tag, bumped once per accepted word and wrapping naturally at 2^TAG_W.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tag <= TAG_INIT;
    end else if (accept) begin
      tag <= tag + 1'b1;
    end
  end

  // Stage 1: capture the word together with the key and tag it was issued with.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_key   <= '0;
      s1_tag   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_key   <= lfsr_q;
      s1_tag   <= tag;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 arithmetic: append an even-parity pad bit, then add the mask modulo 2^61.
  // Decryption discards the pad bit.
  always_comb begin
    mask_b   = key_expand(s1_key);
    padded_x = {s1_data, ^s1_data};
    sum_y    = padded_x + {1'b0, mask_b};
  end

  // Stage 2 register: load when allowed to advance, otherwise hold the presented frame stable.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= {s1_key, sum_y, s1_tag};
      end
    end
  end

endmodule

// File: tb/tb_encrypt_stage_4.sv
// Directed bench for encrypt_stage_4: reset, latency, throughput, wrap, stall, key reload, tag wrap, mid-flight reset.
// Inputs are driven and outputs sampled on the falling edge; an independent model predicts the frames.
// Every scenario runs a fixed number of cycles, so the bench always terminates.
module tb_encrypt_stage_4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        key_load;
  logic [10:0] key_seed;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [77:0] out_data;

  always #5 Clk = ~Clk;

  encrypt_stage_4 #(
    .SEED     (11'h001),
    .TAG_INIT (6'h00)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .key_load  (key_load),
    .key_seed  (key_seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int          tests = 0;
  int          fails = 0;
  logic [10:0] mlfsr;
  logic [5:0]  mtag;
  logic [77:0] expq[$];

  // Builds the mask bit by bit: segment s = i/11 uses key bit i%11, inverted in segments 1, 2 and 4.
  function automatic logic [59:0] m_b(input logic [10:0] k);
    logic [59:0] r;
    for (int i = 0; i < 60; i++) begin
      int   seg;
      logic bt;
      seg = i / 11;
      bt  = k[i % 11];
      if (seg == 1 || seg == 2 || seg == 4) bt = ~bt;
      r[i] = bt;
    end
    return r;
  endfunction

  function automatic logic [77:0] m_frame(input logic [10:0] k, input logic [59:0] d, input logic [5:0] t);
    logic [60:0] x;
    logic [60:0] y;
    x = {d, ^d};
    y = x + {1'b0, m_b(k)};
    return {k, y, t};
  endfunction

  function automatic logic [10:0] m_step(input logic [10:0] l);
    return {l[9:0], l[10] ^ l[8]};
  endfunction

  task automatic do_reset();
    Rst_n = 1'b0; in_valid = 1'b0; key_load = 1'b0; key_seed = '0; in_data = '0; out_ready = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    mlfsr = 11'h001;
    mtag  = 6'h00;
    expq.delete();
  endtask

  // Drives one cycle and updates the model if the word is accepted; returns at the next falling edge.
  task automatic drive(input logic v, input logic [59:0] d, input logic ld, input logic [10:0] sd,
                       input logic ordy, output logic acc);
    in_valid = v; in_data = d; key_load = ld; key_seed = sd; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      expq.push_back(m_frame(mlfsr, d, mtag));
      mtag = mtag + 6'd1;
    end
    if (ld) mlfsr = (sd == 11'h000) ? 11'h001 : sd;
    else if (acc) mlfsr = m_step(mlfsr);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; in_valid = 1'b0; key_load = 1'b0; key_seed = '0; in_data = '0; out_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_hold_valid: got %b expected 0", out_valid); end
    do_reset();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++;
    if (out_data !== 78'h0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_first_word();
    logic acc;
    do_reset();
    drive(1'b1, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL first_lat1: got %b expected 0", out_valid); end
    drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    tests++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL first_lat2: got %b expected 1", out_valid); end
    tests++;
    if (out_data !== {11'h001, 61'h0FFE003FFBFF001, 6'h00}) begin
      fails++; $display("FAIL first_frame: got %h expected %h", out_data, {11'h001, 61'h0FFE003FFBFF001, 6'h00});
    end
    expq.delete();
  endtask

  task automatic test_back_to_back();
    logic [59:0] d3 [3];
    logic [10:0] keys [3];
    logic [77:0] f;
    logic        acc;
    int          k;
    d3   = '{60'h123456789ABCDEF, 60'hFEDCBA987654321, 60'h0F0F0F0F0F0F0F0};
    keys = '{11'h001, 11'h002, 11'h004};
    k    = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(c < 3, (c < 3) ? d3[c] : 60'h0, 1'b0, 11'h0, 1'b1, acc);
      if (c < 3) begin
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL b2b_in_ready c=%0d: got %b expected 1", c, acc); end
      end
      if (out_valid === 1'b1 && k < 3) begin
        f = expq.pop_front();
        tests++;
        if (out_data !== f) begin fails++; $display("FAIL b2b_frame%0d: got %h expected %h", k, out_data, f); end
        tests++;
        if (out_data[77:67] !== keys[k] || out_data[5:0] !== 6'(k)) begin
          fails++; $display("FAIL b2b_key_tag%0d: got %h/%h expected %h/%h", k, out_data[77:67], out_data[5:0], keys[k], k);
        end
        k++;
      end
    end
    tests++;
    if (k !== 3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", k); end
  endtask

  task automatic test_wrap();
    logic        acc;
    logic [60:0] xd;
    do_reset();
    drive(1'b1, 60'hFFF_FFFF_FFFF_FFFF, 1'b0, 11'h0, 1'b1, acc);
    drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    tests++;
    if (out_valid !== 1'b1 || out_data[66:6] !== 61'h0FFE003FFBFEFFF) begin
      fails++; $display("FAIL wrap_y: got %b/%h expected 1/%h", out_valid, out_data[66:6], 61'h0FFE003FFBFEFFF);
    end
    xd = out_data[66:6] - {1'b0, m_b(out_data[77:67])};
    tests++;
    if (xd[60:1] !== 60'hFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL wrap_decrypt: got %h expected %h", xd[60:1], 60'hFFF_FFFF_FFFF_FFFF);
    end
    expq.delete();
  endtask

  task automatic test_backpressure();
    logic        acc;
    logic [77:0] f;
    int          n;
    n = 0;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 60'hA00 + 60'(n), 1'b0, 11'h0, 1'b0, acc);
      if (acc) n++;
      if (c >= 2) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c=%0d: got %b expected 0", c, in_ready); end
        tests++;
        if (out_valid !== 1'b1 || out_data !== expq[0]) begin
          fails++; $display("FAIL bp_stable c=%0d: got %b/%h expected 1/%h", c, out_valid, out_data, expq[0]);
        end
      end
    end
    tests++;
    if (n !== 2) begin fails++; $display("FAIL bp_accepted: got %0d expected 2", n); end
    drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    f = expq.pop_front();
    f = expq.pop_front();
    tests++;
    if (out_valid !== 1'b1 || out_data !== f || out_data[5:0] !== 6'd1) begin
      fails++; $display("FAIL bp_release: got %b/%h expected 1/%h", out_valid, out_data, f);
    end
    drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_key_load_tag_wrap();
    logic        acc;
    logic [77:0] f;
    int          oi;
    oi = 0;
    do_reset();
    for (int i = 0; i < 68; i++) begin
      drive(i < 66, 60'h5A5_0000_0000_0000 + 60'(i * 37), (i == 2), 11'h000, 1'b1, acc);
      if (i < 66) begin
        tests++;
        if (acc !== 1'b1) begin fails++; $display("FAIL kl_in_ready i=%0d: got %b expected 1", i, acc); end
      end
      if (out_valid === 1'b1 && expq.size() > 0) begin
        f = expq.pop_front();
        tests++;
        if (out_data !== f) begin fails++; $display("FAIL kl_frame%0d: got %h expected %h", oi, out_data, f); end
        if (oi == 2) begin
          tests++;
          if (out_data[77:67] !== 11'h004) begin fails++; $display("FAIL kl_old_key: got %h expected 004", out_data[77:67]); end
        end
        if (oi == 3) begin
          tests++;
          if (out_data[77:67] !== 11'h001) begin fails++; $display("FAIL kl_new_key: got %h expected 001", out_data[77:67]); end
        end
        if (oi == 63) begin
          tests++;
          if (out_data[5:0] !== 6'd63) begin fails++; $display("FAIL tag63: got %0d expected 63", out_data[5:0]); end
        end
        if (oi == 64) begin
          tests++;
          if (out_data[5:0] !== 6'd0) begin fails++; $display("FAIL tag_wrap: got %0d expected 0", out_data[5:0]); end
        end
        oi++;
      end
    end
    tests++;
    if (oi !== 66) begin fails++; $display("FAIL kl_count: got %0d expected 66", oi); end
  endtask

  task automatic test_reset_midflight();
    logic        acc;
    logic [77:0] f;
    do_reset();
    drive(1'b1, 60'h111, 1'b0, 11'h0, 1'b1, acc);
    drive(1'b1, 60'h222, 1'b0, 11'h0, 1'b1, acc);
    Rst_n = 1'b0; in_valid = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    Rst_n = 1'b1;
    mlfsr = 11'h001; mtag = 6'h00; expq.delete();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale c=%0d: got %b expected 0", c, out_valid); end
    end
    drive(1'b1, 60'h333, 1'b0, 11'h0, 1'b1, acc);
    drive(1'b0, 60'h0, 1'b0, 11'h0, 1'b1, acc);
    f = expq.pop_front();
    tests++;
    if (out_valid !== 1'b1 || out_data[77:67] !== 11'h001 || out_data[5:0] !== 6'd0 || out_data !== f) begin
      fails++; $display("FAIL mid_restart: got %b/%h expected 1/%h", out_valid, out_data, f);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_key_load_tag_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
